prime_scan_ctrl: RTL and testbench

Sequencing controller for the prime-search datapath. On a `start` request it latches a limit `numMax` and walks every candidate from 2 to `numMax`. Each candidate gets a trial-division test, one divisor per cycle. Each prime found is emitted on a valid/ready output stream, and the controller keeps the running `numberChecked` / `numberOfPrimes` status the prime-number bench already observes. It sits between a host/bench issuing scan requests and downstream consumers of the prime stream.

---
 rtl/prime_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_prime_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prime_scan_ctrl.sv
// Prime-search sequencer: scans 2..numMax by trial division and streams each prime out.
// Optional macro PRIME_SQRT_BOUND_EN selects the d*d > n prime bound instead of d >= n.
module prime_scan_ctrl #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] numMax,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prime,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic [WIDTH-1:0] numberChecked,
  output logic [WIDTH-1:0] numberOfPrimes
);

  localparam int unsigned WIDTH2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TEST = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] n, n_next;
  logic [WIDTH-1:0] d, d_next;
  logic [WIDTH-1:0] limit, limit_next;
  logic [WIDTH-1:0] checked_next, primes_next, prime_next;
  logic             advance;
  logic             bound_hit;
  logic             divides;

  // Prime bound: either the square-root test or the plain linear test.
`ifdef PRIME_SQRT_BOUND_EN
  assign bound_hit = (WIDTH2'(d) * WIDTH2'(d)) > WIDTH2'(n);
`else
  assign bound_hit = (d >= n);
`endif

  assign divides = ((n % d) == '0);

  always_comb begin
    state_next   = state;
    n_next       = n;
    d_next       = d;
    limit_next   = limit;
    checked_next = numberChecked;
    primes_next  = numberOfPrimes;
    prime_next   = prime;
    advance      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          limit_next   = numMax;
          n_next       = WIDTH'(2);
          d_next       = WIDTH'(2);
          checked_next = '0;
          primes_next  = '0;
          state_next   = (numMax < WIDTH'(2)) ? S_DONE : S_TEST;
        end
      end
      S_TEST: begin
        if (bound_hit) begin
          prime_next = n;
          state_next = S_EMIT;
        end else if (divides) begin
          checked_next = n;
          advance      = 1'b1;
        end else begin
          d_next = d + WIDTH'(1);
        end
      end
      S_EMIT: begin
        if (prime_ready) begin
          primes_next  = numberOfPrimes + WIDTH'(1);
          checked_next = n;
          advance      = 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // Limit compare precedes the increment so n never wraps at the top of the range.
    if (advance) begin
      if (n == limit) begin
        state_next = S_DONE;
      end else begin
        n_next     = n + WIDTH'(1);
        d_next     = WIDTH'(2);
        state_next = S_TEST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      n              <= '0;
      d              <= '0;
      limit          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      prime          <= '0;
      prime_valid    <= 1'b0;
      numberChecked  <= '0;
      numberOfPrimes <= '0;
    end else begin
      state          <= state_next;
      n              <= n_next;
      d              <= d_next;
      limit          <= limit_next;
      busy           <= (state_next == S_TEST) || (state_next == S_EMIT);
      done           <= (state_next == S_DONE);
      prime          <= prime_next;
      prime_valid    <= (state_next == S_EMIT);
      numberChecked  <= checked_next;
      numberOfPrimes <= primes_next;
    end
  end

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Directed bench for prime_scan_ctrl: sieve-based scoreboard of expected primes per scan.
module tb_prime_scan_ctrl;

  localparam int unsigned WIDTH = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] numMax;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prime;
  logic             prime_valid;
  logic             prime_ready;
  logic [WIDTH-1:0] numberChecked;
  logic [WIDTH-1:0] numberOfPrimes;

  prime_scan_ctrl #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .numMax         (numMax),
    .busy           (busy),
    .done           (done),
    .prime          (prime),
    .prime_valid    (prime_valid),
    .prime_ready    (prime_ready),
    .numberChecked  (numberChecked),
    .numberOfPrimes (numberOfPrimes)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit sieve[0:2047];
  int exp_count;
  int exp_checked;
  int stall_prime = -1;
  int stall_left  = 0;
  int poke_at     = -1;
  logic [WIDTH-1:0] poke_lim = '0;
  bit saw_valid;
  int last_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic build_sieve();
    for (int i = 0; i <= 2047; i++) sieve[i] = (i >= 2);
    for (int i = 2; i * i <= 2047; i++)
      if (sieve[i])
        for (int j = i * i; j <= 2047; j += i) sieve[j] = 1'b0;
  endtask

  // Drive one start pulse and load the scoreboard with the expected stream.
  task automatic start_scan(input int lim);
    @(negedge clk);
    start  = 1'b1;
    numMax = WIDTH'(lim);
    exp_q.delete();
    exp_count = 0;
    for (int i = 2; i <= lim; i++)
      if (sieve[i]) begin
        exp_q.push_back(i);
        exp_count++;
      end
    exp_checked = (lim < 2) ? 0 : lim;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consume the stream until done; cycle index 1 is the first cycle after start.
  task automatic run_scan(input int budget, output int done_at);
    int k;
    k = 1;
    done_at = -1;
    saw_valid = 1'b0;
    while (k <= budget) begin
      if (k == poke_at) begin
        start  = 1'b1;
        numMax = poke_lim;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_at = k;
        break;
      end
      prime_ready = 1'b1;
      if (prime_valid) begin
        saw_valid = 1'b1;
        if (stall_left > 0 && int'(prime) == stall_prime) begin
          prime_ready = 1'b0;
          chk("stall_prime", 32'(prime), 32'(stall_prime));
          chk("stall_count", 32'(numberOfPrimes), 32'(0));
          stall_left--;
        end else if (exp_q.size() == 0) begin
          chk("extra_prime", 32'(prime), 32'(0));
        end else begin
          last_pop = exp_q.pop_front();
          chk("stream", 32'(prime), 32'(last_pop));
        end
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    prime_ready = 1'b1;
    if (done_at < 0) chk("done_timeout", 32'(k), 32'(0));
  endtask

  task automatic finish_scan(input string tag);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'(0));
    chk({tag, "_count"}, 32'(numberOfPrimes), 32'(exp_count));
    chk({tag, "_checked"}, 32'(numberChecked), 32'(exp_checked));
    chk({tag, "_busy_low"}, 32'(busy), 32'(0));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
    chk({tag, "_count_hold"}, 32'(numberOfPrimes), 32'(exp_count));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_valid"}, 32'(prime_valid), 32'(0));
    chk({tag, "_prime"}, 32'(prime), 32'(0));
    chk({tag, "_checked"}, 32'(numberChecked), 32'(0));
    chk({tag, "_primes"}, 32'(numberOfPrimes), 32'(0));
  endtask

  initial begin
    int d_at;
    int k;
    rst = 1'b1;
    start = 1'b0;
    numMax = '0;
    prime_ready = 1'b1;
    last_pop = 0;
    build_sieve();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    start_scan(35);
    run_scan(5000, d_at);
    finish_scan("max35");

    start_scan(4);
    run_scan(100, d_at);
`ifdef PRIME_SQRT_BOUND_EN
    chk("max4_done_cycle", 32'(d_at), 32'(6));
`else
    chk("max4_done_cycle", 32'(d_at), 32'(7));
`endif
    finish_scan("max4");

    for (int lim = 1; lim >= 0; lim--) begin
      start_scan(lim);
      run_scan(20, d_at);
      chk("small_done_cycle", 32'(d_at), 32'(1));
      chk("small_no_valid", 32'(saw_valid), 32'(0));
      finish_scan("small");
    end
    start_scan(2);
    run_scan(50, d_at);
    chk("max2_last", 32'(last_pop), 32'(2));
    finish_scan("max2");

    stall_prime = 2;
    stall_left  = 5;
    start_scan(10);
    run_scan(2000, d_at);
    chk("stall_consumed", 32'(stall_left), 32'(0));
    finish_scan("stall");
    stall_prime = -1;

    start_scan(100);
    k = 0;
    while (k < 5000 && !(prime_valid && int'(prime) == 13)) begin
      if (prime_valid && exp_q.size() > 0) begin
        last_pop = exp_q.pop_front();
        chk("pre_reset_stream", 32'(prime), 32'(last_pop));
      end
      @(negedge clk);
      k++;
    end
    chk("reached_13", 32'(prime_valid && int'(prime) == 13), 32'(1));
    chk("pre_reset_count", 32'(numberOfPrimes), 32'(5));
    prime_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prime_ready = 1'b1;
    chk_zero("midreset");
    @(negedge clk);
    chk_zero("midreset_idle");

    poke_at  = 3;
    poke_lim = WIDTH'(50);
    start_scan(7);
    run_scan(2000, d_at);
    finish_scan("after_reset");
    poke_at = -1;

`ifdef PRIME_SQRT_BOUND_EN
    start_scan(2047);
    run_scan(60000, d_at);
    chk("edge_last_prime", 32'(last_pop), 32'(2039));
    chk("edge_count_309", 32'(numberOfPrimes), 32'(309));
    finish_scan("edge2047");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
